// File: rtl/issue_window_if.sv
// Decode -> issue handshake bundle for issue_window: enqueue lanes in, issue group out.
interface issue_window_if #(
    parameter int ENQ_WIDTH   = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int PAYLOAD_W   = 64
);
    logic [ENQ_WIDTH-1:0]                  enq_valid;
    logic                                  enq_ready;
    logic [ENQ_WIDTH-1:0][PAYLOAD_W-1:0]   enq_payload;
    logic [ENQ_WIDTH-1:0][5:0]             enq_cls;
    logic [ENQ_WIDTH-1:0]                  enq_we;
    logic [ENQ_WIDTH-1:0][4:0]             enq_waddr;
    logic [ENQ_WIDTH-1:0][4:0]             enq_raddr1;
    logic [ENQ_WIDTH-1:0][4:0]             enq_raddr2;
    logic [ISSUE_WIDTH-1:0]                iss_valid;
    logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0] iss_payload;
    logic                                  iss_ready;

    modport master (
        output enq_valid, enq_payload, enq_cls, enq_we, enq_waddr, enq_raddr1, enq_raddr2, iss_ready,
        input  enq_ready, iss_valid, iss_payload
    );
    modport slave (
        input  enq_valid, enq_payload, enq_cls, enq_we, enq_waddr, enq_raddr1, enq_raddr2, iss_ready,
        output enq_ready, iss_valid, iss_payload
    );
endinterface

// File: rtl/issue_window.sv
// Circular instruction queue selecting an in-order N-way issue group from the head each cycle.
// Optional ISSUE_WINDOW_STATS_EN adds group-size / empty-cycle counters.
package issue_window_pkg;
    // Field order matches the enq_cls lane layout {priv,cmov,jump,store,load,delayslot}.
    typedef struct packed {
        logic       priv;
        logic       cmov;
        logic       jump;
        logic       store;
        logic       load;
        logic       dslot;
        logic       we;
        logic [4:0] waddr;
        logic [4:0] raddr1;
        logic [4:0] raddr2;
    } iw_meta_t;
endpackage

// Pairing check for slot K against slots 0..K-1 (validity of earlier slots handled by the caller).
module iw_slot_chk
    import issue_window_pkg::*;
#(
    parameter int K = 1
) (
    input  iw_meta_t [K:0] win,
    output logic           ok
);
    int   mem_cnt;
    logic unused_bits;

    always_comb begin
        ok          = !(win[K].jump || win[K].priv);
        mem_cnt     = 0;
        unused_bits = ^{win[K].dslot, win[K].we, win[K].waddr};
        for (int j = 0; j <= K; j++)
            if (win[j].load || win[j].store) mem_cnt++;
        if (mem_cnt > 1) ok = 1'b0;
        for (int j = 0; j < K; j++) begin
            unused_bits = unused_bits ^ (^{win[j].cmov, win[j].raddr1, win[j].raddr2});
            if (win[j].jump || win[j].priv || win[j].dslot) ok = 1'b0;
            // RAW is only fatal when the consumer is a cmov or the producer is a load.
            if (win[j].we && win[j].waddr != 5'd0 &&
                (win[j].waddr == win[K].raddr1 || win[j].waddr == win[K].raddr2) &&
                (win[K].cmov || win[j].load))
                ok = 1'b0;
        end
    end
endmodule

module issue_window
    import issue_window_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ENQ_WIDTH   = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int PAYLOAD_W   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    issue_window_if.slave bus
`ifdef ISSUE_WINDOW_STATS_EN
    ,
    output logic [31:0] stat_full_grp,
    output logic [31:0] stat_partial_grp,
    output logic [31:0] stat_empty
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]              head_q, tail_q;
    logic [CW-1:0]              count_q;
    logic [PAYLOAD_W-1:0]       pay_mem  [DEPTH];
    iw_meta_t                   meta_mem [DEPTH];
    iw_meta_t [ISSUE_WIDTH-1:0] win;
    logic [ISSUE_WIDTH-1:0]     slot_ok;
    logic [ISSUE_WIDTH-1:0]     iss_vld;
    logic [CW-1:0]              n_enq, n_iss;
    logic                       enq_fire, iss_fire;

    generate
        for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_slot
            logic [AW-1:0] idx;
            assign idx                = head_q + AW'(k);
            assign win[k]             = meta_mem[idx];
            assign bus.iss_payload[k] = pay_mem[idx];
            if (k == 0) begin : g_head
                assign slot_ok[k] = 1'b1;
            end else begin : g_pair
                iw_slot_chk #(.K(k)) u_chk (.win(win[k:0]), .ok(slot_ok[k]));
            end
        end
    endgenerate

    // Thermometer chain: a slot can only join when every earlier slot joined.
    always_comb begin
        iss_vld    = '0;
        iss_vld[0] = !flush && count_q != '0;
        for (int k = 1; k < ISSUE_WIDTH; k++)
            iss_vld[k] = iss_vld[k-1] && count_q > CW'(k) && slot_ok[k];
    end

    assign bus.iss_valid = iss_vld;
    assign bus.enq_ready = count_q <= CW'(DEPTH - ENQ_WIDTH);
    assign enq_fire      = bus.enq_ready && |bus.enq_valid && !flush;
    assign iss_fire      = bus.iss_ready && iss_vld[0];

    always_comb begin
        n_enq = '0;
        n_iss = '0;
        for (int l = 0; l < ENQ_WIDTH; l++)
            if (enq_fire && bus.enq_valid[l]) n_enq = n_enq + CW'(1);
        for (int k = 0; k < ISSUE_WIDTH; k++)
            if (iss_fire && iss_vld[k]) n_iss = n_iss + CW'(1);
    end

    // Lanes are contiguous from lane 0, so lane l lands at tail+l.
    always_ff @(posedge clk) begin
        for (int l = 0; l < ENQ_WIDTH; l++) begin
            if (enq_fire && bus.enq_valid[l]) begin
                pay_mem[tail_q + AW'(l)]  <= bus.enq_payload[l];
                meta_mem[tail_q + AW'(l)] <= iw_meta_t'({bus.enq_cls[l], bus.enq_we[l], bus.enq_waddr[l],
                                                         bus.enq_raddr1[l], bus.enq_raddr2[l]});
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + n_iss[AW-1:0];
            tail_q  <= tail_q + n_enq[AW-1:0];
            count_q <= count_q + n_enq - n_iss;
        end
    end

`ifdef ISSUE_WINDOW_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_full_grp    <= '0;
            stat_partial_grp <= '0;
            stat_empty       <= '0;
        end else if (!flush) begin
            if (iss_fire && n_iss == CW'(ISSUE_WIDTH)) stat_full_grp    <= stat_full_grp + 32'd1;
            if (iss_fire && n_iss != CW'(ISSUE_WIDTH)) stat_partial_grp <= stat_partial_grp + 32'd1;
            if (count_q == '0)                         stat_empty       <= stat_empty + 32'd1;
        end
    end
`endif
endmodule
